// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul
//   Iterative shift-add multiplier. Operands are accepted over a valid/ready
//   handshake, one partial product is added per cycle for N cycles, and the
//   2N-bit product is presented over a second valid/ready handshake.
//   Signed operation multiplies the magnitudes and negates the result.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for operands (in_ready=1); product holds last value
//   BUSY  | N add/shift iterations in progress (busy=1)
//   DONE  | product valid (out_valid=1), held until out_ready
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (a, b, is_signed)
//   a, b                 N-bit multiplicand / multiplier
//   is_signed            1: two's complement operands and product
//   out_valid, out_ready product handshake
//   product              2N-bit registered result
//   busy                 high while iterating
module seq_shift_add_mul #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   acc;
    logic [CW-1:0]  count;
    logic           sign;

    logic           accept;
    logic           last;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [N:0]     upper;
    logic [N-1:0]   acc_next;
    logic [N-1:0]   mplier_next;
    logic [2*N-1:0] result;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign accept    = in_valid && in_ready;
    assign last      = (count == CW'(N - 1));

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(N-1).
    assign a_mag = (is_signed && a[N-1]) ? -a : a;
    assign b_mag = (is_signed && b[N-1]) ? -b : b;

    // acc holds the upper half of the running sum, mplier the lower half;
    // the add carry enters at the top as the pair shifts right.
    assign upper       = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : '0)};
    assign acc_next    = upper[N:1];
    assign mplier_next = {upper[0], mplier[N-1:1]};
    assign result      = {acc_next, mplier_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = BUSY;
            BUSY:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            sign    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        acc    <= '0;
                        count  <= '0;
                        sign   <= is_signed & (a[N-1] ^ b[N-1]);
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier_next;
                    count  <= count + 1'b1;
                    if (last) begin
                        product <= sign ? -result : result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb_seq_shift_add_mul
//   Scoreboarded bench for seq_shift_add_mul. An N=4 instance is driven with
//   directed and random operations; expected products are queued at issue and
//   a monitor pops and compares them (plus latency) when out_valid appears.
//   An N=8 instance covers the wide-operand corner cases.
module tb_seq_shift_add_mul;

    localparam int N4 = 4;
    localparam int N8 = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv4 = 1'b0, s4 = 1'b0, or4, ir4, ov4, busy4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;

    logic        iv8 = 1'b0, s8 = 1'b0, or8 = 1'b1, ir8, ov8, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    longint      exp4[$];
    int          acc4[$];
    bit          seen4 = 1'b0;
    longint      held4 = 0;

    bit          rand_rdy = 1'b0;
    bit          or_force = 1'b1;

    seq_shift_add_mul #(.N(N4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .is_signed(s4), .out_valid(ov4), .out_ready(or4),
        .product(p4), .busy(busy4)
    );

    seq_shift_add_mul #(.N(N8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .is_signed(s8), .out_valid(ov8), .out_ready(or8),
        .product(p8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        or4 = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            or4 = rand_rdy ? ($urandom_range(0, 3) != 0) : or_force;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: interpret operands at width w, multiply as integers,
    // keep the low 2w bits.
    function automatic longint model(input int w, input logic [7:0] x,
                                     input logic [7:0] y, input bit s);
        longint sx, sy;
        sx = longint'(x);
        sy = longint'(y);
        if (s && x[w-1]) sx = sx - (longint'(1) << w);
        if (s && y[w-1]) sy = sy - (longint'(1) << w);
        return (sx * sy) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Scoreboard monitor for the N=4 instance.
    always @(negedge clk) begin
        if (rst_n && ov4) begin
            if (!seen4) begin
                seen4 = 1'b1;
                if (exp4.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    held4 = exp4.pop_front();
                    check("product4", longint'(p4), held4);
                    check("latency4", longint'(cyc - acc4.pop_front()), N4);
                end
            end else begin
                check("product4_stable", longint'(p4), held4);
            end
            if (or4) seen4 = 1'b0;
        end
    end

    // Issue one N=4 operation; called at posedge+1.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input bit s,
                          input longint e);
        int t = 0;
        iv4 = 1'b1; a4 = a; b4 = b; s4 = s;
        forever begin
            @(negedge clk);
            if (ir4) break;
            t++;
            if (t > 100) begin
                check("accept_timeout4", 0, 1);
                iv4 = 1'b0;
                @(posedge clk); #1;
                return;
            end
        end
        @(posedge clk); #1;
        exp4.push_back(e);
        acc4.push_back(cyc);
        iv4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
    endtask

    task automatic drain4();
        int t = 0;
        while ((exp4.size() != 0 || ov4) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout4", longint'(t < 200), 1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s,
                       input longint e);
        int n = 0;
        iv8 = 1'b1; a8 = a; b8 = b; s8 = s;
        @(negedge clk);
        check("ready8", longint'(ir8), 1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ov8) break;
        end
        check("latency8", longint'(n), N8);
        check("product8", longint'(p8), e);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] ra, rb;
        bit rs;
        int t;

        #12;
        check("rst_in_ready4", longint'(ir4), 1);
        check("rst_out_valid4", longint'(ov4), 0);
        check("rst_busy4", longint'(busy4), 0);
        check("rst_product4", longint'(p4), 0);
        check("rst_product8", longint'(p8), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned corner and signed spot values.
        issue4(4'd15, 4'd15, 1'b0, 64'hE1);
        issue4(4'h8, 4'h8, 1'b1, 64'h40);
        issue4(4'h8, 4'h7, 1'b1, 64'hC8);
        issue4(4'h3, 4'hB, 1'b1, 64'hF1);
        issue4(4'h0, 4'hF, 1'b1, 64'h00);
        issue4(4'h3, 4'hB, 1'b1, model(4, 8'h3, 8'hB, 1'b1));
        drain4();

        // Backpressure in DONE; new operands offered meanwhile are ignored.
        or_force = 1'b0;
        issue4(4'd7, 4'd9, 1'b0, 64'd63);
        t = 0;
        while (!ov4 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("wait_done_timeout", longint'(ov4), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
            @(negedge clk);
            check("stall_out_valid", longint'(ov4), 1);
            check("stall_in_ready", longint'(ir4), 0);
            check("stall_busy", longint'(busy4), 0);
            check("stall_product", longint'(p4), 63);
            @(posedge clk); #1;
        end
        iv4 = 1'b0;
        or_force = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", longint'(ir4), 1);
        check("release_out_valid", longint'(ov4), 0);
        check("release_product_kept", longint'(p4), 63);

        // Reset in the second BUSY cycle discards the operation.
        issue4(4'd9, 4'd7, 1'b0, 64'd63);
        @(posedge clk); #1;
        check("pre_reset_busy", longint'(busy4), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(ov4), 0);
        check("midrst_product", longint'(p4), 0);
        check("midrst_in_ready", longint'(ir4), 1);
        check("midrst_busy", longint'(busy4), 0);
        exp4.delete();
        acc4.delete();
        seen4 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue4(4'd5, 4'd6, 1'b0, 64'h1E);
        drain4();

        // Random operations with random output stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rs = 1'($urandom);
            issue4(ra, rb, rs, model(4, {4'b0, ra}, {4'b0, rb}, rs));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain4();
        rand_rdy = 1'b0;

        // Wide operands.
        op8(8'd255, 8'd255, 1'b0, 64'hFE01);
        op8(8'h80, 8'h80, 1'b1, 64'h4000);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] xa, xb;
            bit xs;
            xa = 8'($urandom);
            xb = 8'($urandom);
            xs = 1'($urandom);
            op8(xa, xb, xs, model(8, xa, xb, xs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
